// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, request record and the
// timeout counter width helper.
package wb_master_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [WB_AW-1:0]     adr;
        logic [WB_DW-1:0]     dat;
        logic [WB_DW/8-1:0]   sel;
    } wb_req_t;

    function automatic int unsigned to_w(input int unsigned timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts BUS cycles without an ack; expired_o flags the cycle whose count would reach
// TIMEOUT_CYC, so a cycle that never sees an ack lasts exactly TIMEOUT_CYC cycles.
module wb_timeout_ctr
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = to_w(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic initiator driven by a valid/ready command port.
// Define WB_MASTER_TIMEOUT_EN to abort cycles that see no ack within TIMEOUT_CYC cycles.
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int unsigned AW          = WB_AW,
    parameter int unsigned DW          = WB_DW,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i
);

    if (DW % 8 != 0) begin : g_dw_chk
        $error("wb_cmd_master: DW must be a multiple of 8");
    end
    if (TIMEOUT_CYC < 1) begin : g_to_chk
        $error("wb_cmd_master: TIMEOUT_CYC must be at least 1");
    end

    state_t          state_q, state_d;
    wb_req_t         req_q, req_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            to_clear;
    logic            to_en;
    logic            to_expired;

`ifdef WB_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    wb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (to_clear),
        .enable_i  (to_en),
        .expired_o (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rsp_dat_d = rsp_dat_q;
        to_clear  = 1'b0;
        to_en     = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = BUS;
                    req_d.we  = cmd_we;
                    req_d.adr = cmd_adr;
                    req_d.dat = cmd_dat;
                    req_d.sel = cmd_sel;
                    to_clear  = 1'b1;
                end
            end
            BUS: begin
                // Ack wins over a timeout that expires in the same cycle.
                if (wbm_ack_i) begin
                    state_d   = RSP;
                    rsp_dat_d = req_q.we ? '0 : wbm_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end else begin
                    to_en = 1'b1;
                    if (to_expired) begin
                        state_d   = RSP;
                        rsp_dat_d = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_err_d = 1'b1;
`endif
                    end
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rsp_dat_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_dat   = rsp_dat_q;
    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_we_o  = req_q.we;
    assign wbm_adr_o = req_q.adr;
    assign wbm_dat_o = req_q.dat;
    assign wbm_sel_o = req_q.sel;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; the timeout scenario runs when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we_o, ack;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .AW          (32),
        .DW          (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we_o),
        .wbm_adr_o (adr_o),
        .wbm_dat_o (dat_o),
        .wbm_sel_o (sel_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = 4'hF;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc", {stb, cyc}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {31'd0, rsp_err} | rsp_dat, 0);
        chk("rst_wbm", {we_o, sel_o} | adr_o | dat_o, 0);
        rst = 1'b0;
        tick();

        // 1: write, ack in the first bus cycle
        issue(1'b1, 32'h3000_0000, 32'hDEAD_BEEF);
        chk("w_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("w_cyc_stb", {cyc, stb}, 2'b11);
        chk("w_we", we_o, 1);
        chk("w_adr", adr_o, 32'h3000_0000);
        chk("w_dat", dat_o, 32'hDEAD_BEEF);
        chk("w_sel", sel_o, 4'hF);
        chk("w_busy", {cmd_ready, rsp_valid}, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("w_cyc_drop", {cyc, stb}, 0);
        chk("w_rsp_valid_2cyc", rsp_valid, 1);
        chk("w_rsp_dat", rsp_dat, 0);
        chk("w_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w_done", {rsp_valid, cmd_ready}, 2'b01);

        // 2: read with three wait states
        issue(1'b0, 32'h3000_0004, 32'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("r_cyc_%0d", i), {cyc, stb, rsp_valid}, 3'b110);
            if (i == 3) begin
                ack   = 1'b1;
                dat_i = 32'h1234_5678;
            end
            tick();
        end
        ack   = 1'b0;
        dat_i = 32'hFFFF_FFFF;
        chk("r_cyc_drop", cyc, 0);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_dat", rsp_dat, 32'h1234_5678);

        // 3: back-pressure with a second command waiting
        issue(1'b1, 32'h3000_0008, 32'h0BAD_F00D);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_%0d", i), {rsp_valid, cmd_ready, cyc}, 3'b100);
            chk($sformatf("bp_dat_%0d", i), rsp_dat, 32'h1234_5678);
            chk($sformatf("bp_adr_%0d", i), adr_o, 32'h3000_0004);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_after_hs", {rsp_valid, cmd_ready, cyc}, 3'b010);
        tick();
        chk("bp_second_acc", {cyc, cmd_ready}, 2'b10);
        chk("bp_second_adr", adr_o, 32'h3000_0008);

        // 4: reset while in BUS
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstbus_cyc", {cyc, stb}, 0);
        chk("rstbus_state", {rsp_valid, cmd_ready}, 2'b01);
        tick(); tick();
        chk("rstbus_no_rsp", {rsp_valid, cmd_ready}, 2'b01);

        // 6: stray ack in IDLE, then a normal read
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("stray_state", {cyc, rsp_valid, cmd_ready}, 3'b001);
        tick();
        chk("stray_no_rsp", rsp_valid, 0);
        issue(1'b0, 32'h3000_000C, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("stray_rd_cyc", cyc, 1);
        ack   = 1'b1;
        dat_i = 32'hA5A5_5A5A;
        tick();
        ack = 1'b0;
        chk("stray_rd_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("stray_rd_dat", rsp_dat, 32'hA5A5_5A5A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("stray_rd_done", cmd_ready, 1);

`ifdef WB_MASTER_TIMEOUT_EN
        // 5: no ack -> abort after 8 bus cycles; then ack in cycle 8 wins
        issue(1'b0, 32'h3000_0010, 32'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_cyc_%0d", i), cyc, 1);
            tick();
        end
        chk("to_cyc_drop", cyc, 0);
        chk("to_rsp", {rsp_valid, rsp_err}, 2'b11);
        chk("to_rsp_dat", rsp_dat, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0014, 32'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_ack_cyc_%0d", i), cyc, 1);
            if (i == 7) begin
                ack   = 1'b1;
                dat_i = 32'h0000_0055;
            end
            tick();
        end
        ack = 1'b0;
        chk("to_ack_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("to_ack_dat", rsp_dat, 32'h0000_0055);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
